// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding,
// one-hot requester codes and default widths.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ0_OH  = 2'b01;
    localparam logic [1:0] REQ1_OH  = 2'b10;

    localparam int DEFAULT_ADDR_W    = 5;
    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_MAX_BURST = 8;

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational 2-way round-robin pick: a lone requester wins outright,
// contention is settled by ptr.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick
);

    always_comb begin
        pick = REQ_NONE;
        case (req)
            2'b01:   pick = REQ0_OH;
            2'b10:   pick = REQ1_OH;
            2'b11:   pick = ptr ? REQ1_OH : REQ0_OH;
            default: pick = REQ_NONE;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between two
// requesters, with an optional bounded locked burst per requester.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_ena,
    output logic              sram_wea,
    input  logic [DATA_W-1:0] sram_dout,
    output logic [1:0]        dbg_state
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);
    localparam bit                LOCK_EN = (MAX_BURST > 1);

    arb_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]       rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       req_vec;
    logic [1:0]       rr_pick;
    logic [1:0]       gnt_vec;

    assign req_vec = {req1, req0};
    assign cnt_inc = burst_cnt_q + CNT_W'(1);

    sram_arb_rr u_rr (
        .req  (req_vec),
        .ptr  (ptr_q),
        .pick (rr_pick)
    );

    // Handshake: req_i is held with its command until gnt_i; the access
    // completes on the rising edge where req_i && gnt_i, and a read returns
    // on rvalid_i exactly one cycle later.
    always_comb begin
        gnt_vec = REQ_NONE;
        if (rst_) begin
            case (state_q)
                ST_IDLE: gnt_vec = rr_pick;
                ST_OWN0: gnt_vec = {1'b0, req0};
                ST_OWN1: gnt_vec = {req1, 1'b0};
                default: gnt_vec = REQ_NONE;
            endcase
        end
    end

    assign gnt0 = gnt_vec[0];
    assign gnt1 = gnt_vec[1];

    always_comb begin
        sram_ena  = |gnt_vec;
        sram_wea  = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        if (gnt_vec[0]) begin
            sram_wea  = we0;
            sram_addr = addr0;
            sram_din  = wdata0;
        end else if (gnt_vec[1]) begin
            sram_wea  = we1;
            sram_addr = addr1;
            sram_din  = wdata1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        rd_owner_d  = REQ_NONE;

        // Every completed access hands priority to the other side, locked or not.
        if (gnt_vec[0]) begin
            ptr_d = 1'b1;
            if (!we0) rd_owner_d = REQ0_OH;
        end else if (gnt_vec[1]) begin
            ptr_d = 1'b0;
            if (!we1) rd_owner_d = REQ1_OH;
        end

        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (LOCK_EN) begin
                    if (gnt_vec[0] && lock0) begin
                        state_d     = ST_OWN0;
                        burst_cnt_d = CNT_W'(1);
                    end else if (gnt_vec[1] && lock1) begin
                        state_d     = ST_OWN1;
                        burst_cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_OWN0: begin
                if (gnt_vec[0]) begin
                    burst_cnt_d = cnt_inc;
                    if (!lock0 || cnt_inc == MAX_CNT) begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = '0;
                    end
                end else if (!req0 && !lock0) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                end
            end
            ST_OWN1: begin
                if (gnt_vec[1]) begin
                    burst_cnt_d = cnt_inc;
                    if (!lock1 || cnt_inc == MAX_CNT) begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = '0;
                    end
                end else if (!req1 && !lock1) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            burst_cnt_q <= '0;
            rd_owner_q  <= REQ_NONE;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    assign rvalid0   = rd_owner_q[0];
    assign rvalid1   = rd_owner_q[1];
    assign rdata0    = sram_dout;
    assign rdata1    = sram_dout;
    assign dbg_state = state_q;

endmodule
